// File: rtl/alu_shifter.sv
// rtl/alu_shifter.sv - registered SLL/SRL/SRA shift unit built on a single logarithmic right-shift core
module alu_shifter #(
    parameter int OPD_LENGTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OPD_LENGTH-1:0] opd1,
    input  logic [OPD_LENGTH-1:0] opd2,
    input  logic [2:0]            alu_op_select,
    output logic [OPD_LENGTH-1:0] shifter_result
);

    localparam int SHW = $clog2(OPD_LENGTH);

    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b111;

    logic [SHW-1:0]        shamt;
    logic                  is_sll;
    logic                  is_srl;
    logic                  is_sra;
    logic                  op_valid;
    logic                  fill;
    logic [OPD_LENGTH-1:0] opd1_rev;
    logic [OPD_LENGTH-1:0] core_in;
    logic [OPD_LENGTH-1:0] core_out;
    logic [OPD_LENGTH-1:0] core_out_rev;
    logic [OPD_LENGTH-1:0] next_result;
    logic [OPD_LENGTH-1:0] stage [SHW+1];

    // Only the low log2(width) bits form the amount; the rest are deliberately dropped.
    assign shamt = opd2[SHW-1:0];
    logic unused_opd2_hi;
    assign unused_opd2_hi = &{1'b0, opd2[OPD_LENGTH-1:SHW]};

    assign is_sll   = (alu_op_select == OP_SLL);
    assign is_srl   = (alu_op_select == OP_SRL);
    assign is_sra   = (alu_op_select == OP_SRA);
    assign op_valid = is_sll | is_srl | is_sra;

    // Sign fill is only meaningful for arithmetic right shifts.
    assign fill = is_sra & opd1[OPD_LENGTH-1];

    // Left shift reuses the right-shift core by mirroring the operand on both sides.
    genvar i;
    generate
        for (i = 0; i < OPD_LENGTH; i++) begin : g_rev
            assign opd1_rev[i]     = opd1[OPD_LENGTH-1-i];
            assign core_out_rev[i] = core_out[OPD_LENGTH-1-i];
        end
    endgenerate

    assign core_in  = is_sll ? opd1_rev : opd1;
    assign stage[0] = core_in;

    // Stage k conditionally moves the word right by 2^k positions.
    genvar k;
    generate
        for (k = 0; k < SHW; k++) begin : g_stage
            localparam int STEP = 1 << k;
            assign stage[k+1] = shamt[k]
                ? {{STEP{fill}}, stage[k][OPD_LENGTH-1:STEP]}
                : stage[k];
        end
    endgenerate

    assign core_out = stage[SHW];

    // Select the final orientation, forcing zero for codes this unit does not handle.
    always_comb begin
        next_result = '0;
        if (op_valid) begin
            next_result = is_sll ? core_out_rev : core_out;
        end
    end

    // Single result register; reset clears it without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shifter_result <= '0;
        end else begin
            shifter_result <= next_result;
        end
    end

endmodule

// File: tb/tb_alu_shifter.sv
// tb/tb_alu_shifter.sv - self-checking bench for alu_shifter with directed vectors and an exhaustive sweep
module tb_alu_shifter;

    logic       clk;
    logic       rst;
    logic [7:0] opd1;
    logic [7:0] opd2;
    logic [2:0] alu_op_select;
    logic [7:0] shifter_result;

    int total;
    int bad;
    logic [7:0] last_exp;

    alu_shifter #(.OPD_LENGTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .opd1           (opd1),
        .opd2           (opd2),
        .alu_op_select  (alu_op_select),
        .shifter_result (shifter_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic signed [7:0] sa;
        logic [2:0]        s;
        s  = b[2:0];
        sa = a;
        case (op)
            3'b011:  return a << s;
            3'b001:  return a >> s;
            3'b111:  return sa >>> s;
            default: return 8'h00;
        endcase
    endfunction

    // Drive a vector away from the edge, confirm the output has not moved yet,
    // then confirm the hand-computed result appears after exactly one edge.
    task automatic run(input string tag, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] exp);
        @(negedge clk);
        alu_op_select = op;
        opd1 = a;
        opd2 = b;
        #1;
        check({tag, "_hold"}, shifter_result, last_exp);
        @(posedge clk);
        #1;
        check(tag, shifter_result, exp);
        last_exp = exp;
    endtask

    initial begin
        logic [7:0] prev_exp;
        logic [2:0] ops [5];
        total = 0;
        bad   = 0;

        rst = 1'b1;
        alu_op_select = 3'b011;
        opd1 = 8'hFF;
        opd2 = 8'h01;
        #1;
        check("rst_immediate", shifter_result, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold", shifter_result, 8'h00);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_release_before_edge", shifter_result, 8'h00);
        @(posedge clk);
        #1;
        check("rst_release_first_edge", shifter_result, 8'hFE);
        last_exp = 8'hFE;

        run("sll_0f_3", 3'b011, 8'h0F, 8'h03, 8'h78);
        run("srl_f0_3", 3'b001, 8'hF0, 8'h03, 8'h1E);
        run("sra_e0_3", 3'b111, 8'hE0, 8'h03, 8'hFC);
        run("sra_60_3", 3'b111, 8'h60, 8'h03, 8'h0C);

        run("sll_0f_0", 3'b011, 8'h0F, 8'h00, 8'h0F);
        run("srl_f0_0", 3'b001, 8'hF0, 8'h00, 8'hF0);
        run("sra_e0_0", 3'b111, 8'hE0, 8'h00, 8'hE0);

        run("inv_000", 3'b000, 8'hAA, 8'h01, 8'h00);
        run("sll_aa_1", 3'b011, 8'hAA, 8'h01, 8'h54);
        run("inv_110", 3'b110, 8'hAA, 8'h01, 8'h00);

        run("sll_mask_0b", 3'b011, 8'h01, 8'h0B, 8'h08);
        run("sra_80_7", 3'b111, 8'h80, 8'h07, 8'hFF);
        run("srl_80_7", 3'b001, 8'h80, 8'h07, 8'h01);
        run("sll_80_7_hi", 3'b011, 8'h03, 8'hF7, 8'h80);

        // Exhaustive sweep, op changing every cycle, pipelined one-cycle check.
        ops[0] = 3'b011;
        ops[1] = 3'b001;
        ops[2] = 3'b111;
        ops[3] = 3'b010;
        ops[4] = 3'b101;
        prev_exp = last_exp;
        for (int a = 0; a < 256; a++) begin
            for (int s = 0; s < 8; s++) begin
                for (int o = 0; o < 5; o++) begin
                    @(negedge clk);
                    check("sweep", shifter_result, prev_exp);
                    alu_op_select = ops[o];
                    opd1 = 8'(a);
                    opd2 = {5'(o * 3 + s), 3'(s)};
                    prev_exp = model(ops[o], 8'(a), {5'(o * 3 + s), 3'(s)});
                end
            end
        end
        @(negedge clk);
        check("sweep_last", shifter_result, prev_exp);

        // Async reset pulse between edges discards the in-flight result.
        alu_op_select = 3'b001;
        opd1 = 8'hC3;
        opd2 = 8'h02;
        @(posedge clk);
        #1;
        check("pre_midrst", shifter_result, 8'h30);
        @(negedge clk);
        alu_op_select = 3'b111;
        opd1 = 8'h90;
        opd2 = 8'h01;
        #1;
        rst = 1'b1;
        #1;
        check("midrst_clear", shifter_result, 8'h00);
        rst = 1'b0;
        #1;
        check("midrst_stays_clear", shifter_result, 8'h00);
        @(posedge clk);
        #1;
        check("midrst_reload", shifter_result, 8'hC8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_shifter.md
# alu_shifter

Shift unit of the ALU. Performs logical left, logical right and arithmetic right shifts of `opd1` by an amount taken from `opd2`, selected by the ALU operation code. The unit implements the RISC-V SLL/SLLI, SRL/SRLI and SRA/SRAI instructions. The result is registered once and feeds the ALU result multiplexer.

## Interface
- `OPD_LENGTH`, default 8: operand and result width in bits. Must be a power of two, at least 2 (32 in the RV32 core).
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high; clears the result register.
- `opd1`  input  OPD_LENGTH  value to be shifted.
- `opd2`  input  OPD_LENGTH  shift amount source; only the low log2(OPD_LENGTH) bits are used.
- `alu_op_select`  input  3  operation select: 3'b011 SLL/SLLI, 3'b001 SRL/SRLI, 3'b111 SRA/SRAI; every other code is invalid for this unit.
- `shifter_result`  output  OPD_LENGTH  registered shift result.

## Operation
- Shift amount: `shamt = opd2[log2(OPD_LENGTH)-1:0]`.
  - Upper bits of `opd2` are ignored, so opd2 = 8'h0B with OPD_LENGTH = 8 shifts by 3.
  - The unit never shifts by OPD_LENGTH or more.
- SLL (011): `opd1 << shamt`, zero fill from the LSB side.
- SRL (001): `opd1 >> shamt`, zero fill from the MSB side.
- SRA (111): `opd1 >> shamt`, fill with `opd1[OPD_LENGTH-1]` (sign extension).
- Invalid codes (000, 010, 100, 101, 110): next result is all zeros.
- `shamt = 0`: result equals `opd1` unmodified for all three valid ops.
- Datapath structure:
  - Logarithmic barrel shifter with log2(OPD_LENGTH) stages; stage k shifts by 2^k when `shamt[k]` is set.
  - A single right-shift core serves all three ops; SLL is realised by bit-reversing the input and the output.
  - Fill bit = `opd1[MSB]` only for SRA, else 0.
- No internal state other than the result register. No overflow or flag outputs.

## Timing
- Inputs are sampled on each rising edge of `clk`. `shifter_result` shows the result for those inputs after that edge.
- Latency: exactly 1 cycle. Throughput: one operation per cycle, with no handshake and no stall.
- `rst` asserted: `shifter_result` goes to 0 immediately, without waiting for a clock edge, and holds 0 while `rst` is high.
- First rising edge after `rst` deasserts: the register loads the shift of the inputs present at that edge.
- Reset mid-stream: any result in flight is discarded and not recovered.
- Changes to inputs between edges have no effect on `shifter_result` until the next edge. The combinational path from inputs to register D must close timing within one clock period.
- Output is fully defined (never X) after reset, provided the inputs are driven.

## Test plan
- Reset: assert `rst` with opd1=8'hFF, opd2=8'h01, op=011 -> `shifter_result`=8'h00 immediately and across clock edges. Release `rst` -> 8'hFE one edge later.
- Nonzero shifts, OPD_LENGTH=8, one per cycle:
  - SLL 8'h0F by 3 -> 8'h78
  - SRL 8'hF0 by 3 -> 8'h1E
  - SRA 8'hE0 by 3 -> 8'hFC
  - SRA 8'h60 by 3 -> 8'h0C
  - Check each result appears exactly one cycle after it is applied.
- Zero shift: SLL 8'h0F, SRL 8'hF0 and SRA 8'hE0, each with opd2=8'h00 -> 8'h0F, 8'hF0 and 8'hE0 respectively.
- Invalid op: op=000 and op=110 with opd1=8'hAA, opd2=8'h01 -> 8'h00.
- Amount masking and extremes:
  - SLL 8'h01 with opd2=8'h0B -> 8'h08
  - SRA 8'h80 by 7 -> 8'hFF
  - SRL 8'h80 by 7 -> 8'h01
- Exhaustive/random: all ops × all opd1 × shamt 0..7, compared against a behavioral model with a one-cycle delay. Include a back-to-back op change every cycle, and an async `rst` pulse between edges that clears the output mid-stream.
